// File: rtl/rv_pkg.sv
// rv_pkg -- shared constants for the IF/ID pipeline register.
//   * RV32 base opcodes recognised by the decoder
//   * fmt_t   : instruction class reported on out_fmt
//   * state_t : occupancy of the output register / skid entry pair
package rv_pkg;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I_ALU   = 3'd1,
        FMT_LOAD    = 3'd2,
        FMT_STORE   = 3'd3,
        FMT_BRANCH  = 3'd4,
        FMT_ILLEGAL = 3'd7
    } fmt_t;

    // EMPTY: nothing held; FULL: output register valid;
    // SKID: output register and skid entry both valid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

endpackage

// File: rtl/imm_gen.sv
// imm_gen -- purely combinational instruction classifier and immediate
// generator.
//   instr : 32-bit instruction word
//   imm   : XLEN-bit sign-extended immediate (0 for R and ILLEGAL)
//   fmt   : instruction class (rv_pkg::fmt_t)
module imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_t            fmt
);

    // Every immediate fits in 13 bits (branch is the widest); the narrower
    // ones are pre-extended by one bit before the call.
    function automatic logic signed [XLEN-1:0] sext13(input logic signed [12:0] v);
        return {{(XLEN-13){v[12]}}, v};
    endfunction

    logic signed [XLEN-1:0] imm_s;

    always_comb begin
        fmt   = FMT_ILLEGAL;
        imm_s = '0;
        case (instr[6:0])
            OPC_R: begin
                fmt = FMT_R;
            end
            OPC_I_ALU: begin
                fmt   = FMT_I_ALU;
                imm_s = sext13({instr[31], instr[31:20]});
            end
            OPC_LOAD: begin
                fmt   = FMT_LOAD;
                imm_s = sext13({instr[31], instr[31:20]});
            end
            OPC_STORE: begin
                fmt   = FMT_STORE;
                imm_s = sext13({instr[31], instr[31:25], instr[11:7]});
            end
            OPC_BRANCH: begin
                // Branch offsets are in bytes, so bit 0 is always zero
                fmt   = FMT_BRANCH;
                imm_s = sext13({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
            end
            default: begin
                fmt   = FMT_ILLEGAL;
                imm_s = '0;
            end
        endcase
    end

    assign imm = imm_s;

    // funct3 and rs1 never contribute to an immediate
    logic unused_bits;
    assign unused_bits = ^instr[19:12];

endmodule

// File: rtl/if_id_pipe.sv
// if_id_pipe -- fetch/decode pipeline register with a single skid entry.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        fetch-side handshake (in_ready is registered)
//   in_instr, in_pc          fetched instruction and its address
//   flush                    drop everything held plus any same-cycle input
//   out_valid/out_ready      decode-side handshake
//   out_instr, out_pc        held instruction and its address
//   out_opcode .. out_funct7 raw fields of out_instr
//   out_imm, out_fmt         sign-extended immediate and instruction class
//   out_illegal              out_fmt is ILLEGAL while out_valid
//
// in_ready is a flop so fetch never sees a combinational path from
// out_ready; the skid entry absorbs the one beat that can arrive in the
// cycle the downstream stalls.
module if_id_pipe
    import rv_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    state_t          state;
    logic            in_ready_q;
    logic [31:0]     hold_instr_p1;
    logic [PC_W-1:0] hold_pc_p1;
    logic [31:0]     skid_instr_p1;
    logic [PC_W-1:0] skid_pc_p1;

    logic in_xfer;
    logic out_xfer;

    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid && out_ready;

    // ---- fetch -> output register / skid entry ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_EMPTY;
            in_ready_q    <= 1'b0;
            hold_instr_p1 <= '0;
            hold_pc_p1    <= '0;
            skid_instr_p1 <= '0;
            skid_pc_p1    <= '0;
        end else if (flush) begin
            // Flush wins over every handshake; the held words are left in
            // place but are invisible once out_valid drops.
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (in_xfer) begin
                        hold_instr_p1 <= in_instr;
                        hold_pc_p1    <= in_pc;
                        state         <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        hold_instr_p1 <= in_instr;
                        hold_pc_p1    <= in_pc;
                        in_ready_q    <= 1'b1;
                    end else if (out_xfer) begin
                        state      <= ST_EMPTY;
                        in_ready_q <= 1'b1;
                    end else if (in_xfer) begin
                        // Downstream stalled while a beat was accepted
                        skid_instr_p1 <= in_instr;
                        skid_pc_p1    <= in_pc;
                        state         <= ST_SKID;
                        in_ready_q    <= 1'b0;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so no input can arrive
                    if (out_xfer) begin
                        hold_instr_p1 <= skid_instr_p1;
                        hold_pc_p1    <= skid_pc_p1;
                        state         <= ST_FULL;
                        in_ready_q    <= 1'b1;
                    end else begin
                        in_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // ---- output register -> decode ----
    fmt_t            dec_fmt;
    logic [XLEN-1:0] dec_imm;

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (hold_instr_p1),
        .imm   (dec_imm),
        .fmt   (dec_fmt)
    );

    assign out_instr   = hold_instr_p1;
    assign out_pc      = hold_pc_p1;
    assign out_opcode  = hold_instr_p1[6:0];
    assign out_rd      = hold_instr_p1[11:7];
    assign out_funct3  = hold_instr_p1[14:12];
    assign out_rs1     = hold_instr_p1[19:15];
    assign out_rs2     = hold_instr_p1[24:20];
    assign out_funct7  = hold_instr_p1[31:25];

    // Class and immediate read as zero whenever nothing is presented
    assign out_fmt     = out_valid ? 3'(dec_fmt) : 3'd0;
    assign out_imm     = out_valid ? dec_imm : '0;
    assign out_illegal = out_valid && (dec_fmt == FMT_ILLEGAL);

endmodule

// File: tb/tb_if_id_pipe.sv
// tb_if_id_pipe -- directed vectors for if_id_pipe with hand-computed
// expected values.
`timescale 1ns/1ps
module tb_if_id_pipe;

    localparam int PC_W = 8;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    if_id_pipe #(.PC_W(PC_W), .XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [7:0] pc,
                         input logic ordy);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
    endtask

    localparam logic [31:0] I_ADDI = 32'hFFD0_8293;
    localparam logic [31:0] I_SD   = 32'h0021_B423;
    localparam logic [31:0] I_BEQ  = 32'hFE20_8EE3;
    localparam logic [31:0] I_BAD  = 32'h0000_007F;
    localparam logic [31:0] I_A    = 32'h0010_0093;  // addi x1,x0,1
    localparam logic [31:0] I_B    = 32'h0020_0113;  // addi x2,x0,2
    localparam logic [31:0] I_C    = 32'h0030_0193;  // addi x3,x0,3

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 8'h0, 1'b0);

        // Reset state
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_fmt", out_fmt, 0);
        #3 rst = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // addi x5,x1,-3 at pc 0x10
        drive(1'b1, I_ADDI, 8'h10, 1'b1);
        tick();
        chk("addi_valid", out_valid, 1);
        chk("addi_rd", out_rd, 5);
        chk("addi_rs1", out_rs1, 1);
        chk("addi_fmt", out_fmt, 1);
        chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("addi_pc", out_pc, 8'h10);
        chk("addi_opcode", out_opcode, 7'h13);
        chk("addi_illegal", out_illegal, 0);

        // sd x2,8(x3): FULL with simultaneous in/out transfer
        drive(1'b1, I_SD, 8'h14, 1'b1);
        tick();
        chk("sd_valid", out_valid, 1);
        chk("sd_fmt", out_fmt, 3);
        chk("sd_rs1", out_rs1, 3);
        chk("sd_rs2", out_rs2, 2);
        chk("sd_funct3", out_funct3, 3);
        chk("sd_imm", out_imm, 8);
        chk("sd_pc", out_pc, 8'h14);

        // beq x1,x2,-4
        drive(1'b1, I_BEQ, 8'h18, 1'b1);
        tick();
        chk("beq_fmt", out_fmt, 4);
        chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_funct7", out_funct7, 7'h7F);

        // Unknown opcode
        drive(1'b1, I_BAD, 8'h1C, 1'b1);
        tick();
        chk("bad_fmt", out_fmt, 7);
        chk("bad_illegal", out_illegal, 1);
        chk("bad_imm", out_imm, 0);

        // Drain: output only -> EMPTY, decode outputs read zero
        drive(1'b0, 32'h0, 8'h0, 1'b1);
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_fmt", out_fmt, 0);
        chk("drain_illegal", out_illegal, 0);
        chk("drain_imm", out_imm, 0);
        chk("drain_in_ready", in_ready, 1);

        // Back-to-back A,B,C with downstream stalling from the second cycle
        drive(1'b1, I_A, 8'h20, 1'b1);
        tick();
        chk("abc_a_out", out_instr, I_A);
        drive(1'b1, I_B, 8'h24, 1'b0);
        tick();
        chk("abc_skid_in_ready", in_ready, 0);
        chk("abc_skid_out", out_instr, I_A);
        drive(1'b1, I_C, 8'h28, 1'b0);
        tick();
        chk("abc_hold_in_ready", in_ready, 0);
        chk("abc_hold_out", out_instr, I_A);
        chk("abc_hold_pc", out_pc, 8'h20);
        out_ready = 1'b1;          // A leaves, B moves up
        tick();
        chk("abc_b_out", out_instr, I_B);
        chk("abc_b_pc", out_pc, 8'h24);
        chk("abc_b_in_ready", in_ready, 1);
        tick();                    // B leaves, C accepted
        chk("abc_c_out", out_instr, I_C);
        chk("abc_c_valid", out_valid, 1);
        in_valid = 1'b0;
        tick();                    // C leaves
        chk("abc_empty", out_valid, 0);

        // Flush in SKID with a beat offered at the input
        drive(1'b1, I_A, 8'h30, 1'b0);
        tick();
        drive(1'b1, I_B, 8'h34, 1'b0);
        tick();
        chk("fl_pre_in_ready", in_ready, 0);
        drive(1'b1, I_C, 8'h38, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        drive(1'b0, 32'h0, 8'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_nothing_emitted", out_valid, 0);
        end

        // Flush in FULL discards the same-cycle accepted beat
        drive(1'b1, I_A, 8'h40, 1'b0);
        tick();
        chk("flf_full", out_valid, 1);
        drive(1'b1, I_B, 8'h44, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 8'h0, 1'b1);
        chk("flf_out_valid", out_valid, 0);
        tick();
        chk("flf_stays_empty", out_valid, 0);

        // Asynchronous reset pulse between clock edges
        drive(1'b1, I_BEQ, 8'h50, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("ar_full", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_in_ready", in_ready, 0);
        chk("ar_out_instr", out_instr, 0);
        #1 rst = 1'b0;
        tick();
        chk("ar_in_ready_after", in_ready, 1);
        chk("ar_out_valid_after", out_valid, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
